// File: rtl/data_mem_ctrl_if.sv
// Request/response bus of the MEM-stage data memory.
// master: pipeline side issuing loads/stores; slave: data_mem_ctrl.
interface data_mem_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int BYTES = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [BYTES-1:0]  req_be;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: word-organised data memory with byte-lane writes, a
// configurable read latency (READ_LAT = 1..4) and valid/ready request and
// response channels. Only one access is in flight at a time.
// Misaligned or out-of-range accesses return resp_err and never write.
// Optional feature macro: DMEM_WR_RESP_EN -- when defined, successful writes
// also produce a response beat; otherwise they complete silently in IDLE.
module data_mem_ctrl #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int DEPTH    = 64,
  parameter int READ_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  data_mem_ctrl_if.slave bus
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF   = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 3;

  // Byte-offset mask and first illegal byte address (one extra bit so the
  // compare cannot wrap when DEPTH*BYTES equals 2**ADDR_W).
  localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(BYTES - 1);
  localparam logic [ADDR_W:0]   LIMIT     = (ADDR_W + 1)'(DEPTH * BYTES);
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(READ_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Address is not word aligned.
  function automatic logic f_misaligned(input logic [ADDR_W-1:0] addr);
    f_misaligned = ((addr & ADDR_MASK) != {ADDR_W{1'b0}});
  endfunction

  // Address lies beyond the last byte of the array.
  function automatic logic f_out_of_range(input logic [ADDR_W-1:0] addr);
    f_out_of_range = ({1'b0, addr} >= LIMIT);
  endfunction

  logic [DATA_W-1:0] r_mem [DEPTH];

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_rdata;
  logic              r_resp_err;

  state_t            w_state_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic              w_resp_valid_nxt;
  logic [DATA_W-1:0] w_resp_rdata_nxt;
  logic              w_resp_err_nxt;
  logic              w_mem_we;

  logic              w_req_ready;
  logic              w_accept;
  logic              w_req_err;
  logic [IDX_W-1:0]  w_req_idx;

  // req_ready is forced low while reset is asserted, independent of state.
  assign w_req_ready = (r_state == ST_IDLE) & rst_n;
  assign w_accept    = bus.req_valid & w_req_ready;
  assign w_req_idx   = bus.req_addr[OFF +: IDX_W];
  assign w_req_err   = f_misaligned(bus.req_addr) | f_out_of_range(bus.req_addr);

  assign bus.req_ready  = w_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;

  // Next-state and next-output decode for the IDLE/BUSY/RESP sequence.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_idx_nxt        = r_idx;
    w_resp_valid_nxt = r_resp_valid;
    w_resp_rdata_nxt = r_resp_rdata;
    w_resp_err_nxt   = r_resp_err;
    w_mem_we         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_idx_nxt = w_req_idx;
          if (w_req_err) begin
            // Illegal address: no array access, report the error directly.
            w_state_nxt      = ST_RESP;
            w_resp_valid_nxt = 1'b1;
            w_resp_err_nxt   = 1'b1;
            w_resp_rdata_nxt = {DATA_W{1'b0}};
          end else if (bus.req_we) begin
            w_mem_we = 1'b1;
`ifdef DMEM_WR_RESP_EN
            w_state_nxt      = ST_RESP;
            w_resp_valid_nxt = 1'b1;
            w_resp_err_nxt   = 1'b0;
            w_resp_rdata_nxt = {DATA_W{1'b0}};
`else
            // Write completes silently; stay ready for the next request.
            w_state_nxt = ST_IDLE;
`endif
          end else if (READ_LAT == 32'd1) begin
            w_state_nxt      = ST_RESP;
            w_resp_valid_nxt = 1'b1;
            w_resp_err_nxt   = 1'b0;
            w_resp_rdata_nxt = r_mem[w_req_idx];
          end else begin
            w_state_nxt = ST_BUSY;
            w_cnt_nxt   = CNT_LOAD;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_BUSY: begin
        // Counter holds the number of edges still to wait, including the
        // capture edge; the word is sampled when it is down to one.
        if (r_cnt == 3'd1) begin
          w_state_nxt      = ST_RESP;
          w_cnt_nxt        = 3'd0;
          w_resp_valid_nxt = 1'b1;
          w_resp_err_nxt   = 1'b0;
          w_resp_rdata_nxt = r_mem[r_idx];
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end

      ST_RESP: begin
        if (bus.resp_ready) begin
          w_state_nxt      = ST_IDLE;
          w_resp_valid_nxt = 1'b0;
          w_resp_err_nxt   = 1'b0;
          w_resp_rdata_nxt = {DATA_W{1'b0}};
        end else begin
          w_state_nxt = ST_RESP;
        end
      end

      default: begin
        w_state_nxt      = ST_IDLE;
        w_cnt_nxt        = 3'd0;
        w_resp_valid_nxt = 1'b0;
        w_resp_err_nxt   = 1'b0;
        w_resp_rdata_nxt = {DATA_W{1'b0}};
      end
    endcase
  end

  // State, counter and response registers; reset drops any pending access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 3'd0;
      r_idx        <= {IDX_W{1'b0}};
      r_resp_valid <= 1'b0;
      r_resp_rdata <= {DATA_W{1'b0}};
      r_resp_err   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
      r_resp_err   <= w_resp_err_nxt;
    end
  end

  // Storage array, deliberately not reset; enabled byte lanes written on accept.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BYTES; i++) begin
      if (w_mem_we && bus.req_be[i]) begin
        r_mem[w_req_idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
      end
    end
  end

endmodule
